// File: rtl/wb_write_queue.sv
// Writeback queue: 2-entry FIFO between MEM/WB and the dual-write register file,
// with decode-stage bypass. Optional hardwired-zero R0 handling under WB_ZERO_REG_EN.
module wb_write_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op2,
    input  logic [ADDR_W-1:0] in_addr1,
    input  logic [ADDR_W-1:0] in_addr2,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              hold,
    input  logic              flush,
    output logic              rf_we,
    output logic              rf_op2,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    output logic [DATA_W-1:0] rf_data1,
    output logic [DATA_W-1:0] rf_data2,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic [1:0]        count
);

    logic [1:0]             op2_q;
    logic [1:0]             kill_q;
    logic [1:0][ADDR_W-1:0] addr1_q;
    logic [1:0][ADDR_W-1:0] addr2_q;
    logic [1:0][DATA_W-1:0] data1_q;
    logic [1:0][DATA_W-1:0] data2_q;

    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;

    logic push;
    logic pop;

    logic              st_op2;
    logic              st_kill;
    logic [ADDR_W-1:0] st_addr1;
    logic [DATA_W-1:0] st_data1;

    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = (count_q != 2'd0) & ~hold & ~flush;

`ifdef WB_ZERO_REG_EN
    logic w1_live;
    logic w2_live;

    // A masked first write is folded into slot 1 so the RF port stays a plain single write.
    always_comb begin
        w1_live  = (in_addr1 != '0);
        w2_live  = in_op2 & (in_addr2 != '0);
        st_op2   = w1_live & w2_live;
        st_kill  = ~w1_live & ~w2_live;
        st_addr1 = w1_live ? in_addr1 : in_addr2;
        st_data1 = w1_live ? in_data1 : in_data2;
    end
`else
    always_comb begin
        st_op2   = in_op2;
        st_kill  = 1'b0;
        st_addr1 = in_addr1;
        st_data1 = in_data1;
    end
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = 2'd0;
        end else begin
            if (pop)  head_d = ~head_q;
            if (push) tail_d = ~tail_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op2_q   <= '0;
            kill_q  <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else if (push) begin
            op2_q[tail_q]   <= st_op2;
            kill_q[tail_q]  <= st_kill;
            addr1_q[tail_q] <= st_addr1;
            addr2_q[tail_q] <= in_addr2;
            data1_q[tail_q] <= st_data1;
            data2_q[tail_q] <= in_data2;
        end
    end

    assign rf_we    = (count_q != 2'd0) & ~hold & ~kill_q[head_q];
    assign rf_op2   = op2_q[head_q];
    assign rf_addr1 = addr1_q[head_q];
    assign rf_addr2 = addr2_q[head_q];
    assign rf_data1 = data1_q[head_q];
    assign rf_data2 = data2_q[head_q];
    assign count    = count_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [ADDR_W-1:0] rd;
        logic              hit;
        logic [DATA_W-1:0] data;
        logic              slot;
        logic              live;

        assign rd = (gi == 0) ? rd_addr_a : rd_addr_b;

        // Older entry is scanned first so a younger match overrides it; addr2 overrides addr1
        // because the register file keeps data2 on a duplicate destination.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            slot = head_q;
            live = 1'b0;
            for (int k = 0; k < 2; k++) begin
                slot = (k == 0) ? head_q : ~tail_q;
                live = (k == 0) ? (count_q == 2'd2) : (count_q != 2'd0);
                if (live && !kill_q[slot]) begin
                    if (addr1_q[slot] == rd) begin
                        hit  = 1'b1;
                        data = data1_q[slot];
                    end
                    if (op2_q[slot] && (addr2_q[slot] == rd)) begin
                        hit  = 1'b1;
                        data = data2_q[slot];
                    end
                end
            end
`ifdef WB_ZERO_REG_EN
            if (rd == '0) begin
                hit  = 1'b0;
                data = '0;
            end
`endif
        end
    end

    assign fwd_hit_a  = g_fwd[0].hit;
    assign fwd_data_a = g_fwd[0].data;
    assign fwd_hit_b  = g_fwd[1].hit;
    assign fwd_data_b = g_fwd[1].data;

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model, per-cycle compare of every
// output, architectural register-file shadow, and directed literal checks.
module tb_wb_write_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op2;
    logic [3:0]  in_addr1;
    logic [3:0]  in_addr2;
    logic [15:0] in_data1;
    logic [15:0] in_data2;
    logic        hold;
    logic        flush;
    logic        rf_we;
    logic        rf_op2;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        fwd_hit_a;
    logic [15:0] fwd_data_a;
    logic        fwd_hit_b;
    logic [15:0] fwd_data_b;
    logic [1:0]  count;

    wb_write_queue #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op2(in_op2),
        .in_addr1(in_addr1), .in_addr2(in_addr2),
        .in_data1(in_data1), .in_data2(in_data2),
        .hold(hold), .flush(flush),
        .rf_we(rf_we), .rf_op2(rf_op2),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One queued result expressed as the register writes it will cause, in order.
    typedef struct packed {
        logic        w1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        w2;
        logic [3:0]  a2;
        logic [15:0] d2;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] gold_rf [16];
    logic [15:0] dut_rf  [16];
    int          n_vec = 0;
    int          n_err = 0;

    int   m_sz;
    bit   m_pop;
    bit   m_push;
    ent_t m_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic ent_t mk_entry(input logic op2, input logic [3:0] a1, input logic [3:0] a2,
                                      input logic [15:0] d1, input logic [15:0] d2);
        ent_t e;
        e.w1 = 1'b1; e.a1 = a1; e.d1 = d1;
        e.w2 = op2;  e.a2 = a2; e.d2 = d2;
`ifdef WB_ZERO_REG_EN
        if (a1 == 4'd0) e.w1 = 1'b0;
        if (a2 == 4'd0) e.w2 = 1'b0;
`endif
        return e;
    endfunction

    function automatic void mfwd(input logic [3:0] rd, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = 16'h0;
        for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
            if (mq[i].w2 && mq[i].a2 == rd) begin
                hit = 1'b1; d = mq[i].d2;
            end else if (mq[i].w1 && mq[i].a1 == rd) begin
                hit = 1'b1; d = mq[i].d1;
            end
        end
    endfunction

    // Reference model plus a shadow RF fed only by what the DUT actually drove.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            for (int r = 0; r < 16; r++) begin
                gold_rf[r] = 16'h0;
                dut_rf[r]  = 16'h0;
            end
        end else begin
            m_sz   = mq.size();
            m_pop  = (m_sz != 0) && !hold && !flush;
            m_push = in_valid && (m_sz != 2) && !flush;
            if (rf_we) begin
                dut_rf[rf_addr1] = rf_data1;
                if (rf_op2) dut_rf[rf_addr2] = rf_data2;
            end
            if (m_pop) begin
                m_e = mq.pop_front();
                if (m_e.w1) gold_rf[m_e.a1] = m_e.d1;
                if (m_e.w2) gold_rf[m_e.a2] = m_e.d2;
            end
            if (flush) mq.delete();
            if (m_push) mq.push_back(mk_entry(in_op2, in_addr1, in_addr2, in_data1, in_data2));
        end
    end

    always @(posedge clk) begin
        if (rst) assert (!(flush && !hold)) else $error("flush asserted without hold");
    end

    task automatic compare_all();
        int          sz;
        logic        exp_we;
        logic        h;
        logic [15:0] d;
        int          bad;
        sz     = mq.size();
        exp_we = (sz != 0) && !hold && (mq[0].w1 || mq[0].w2);
        chk("count", count, sz);
        chk("in_ready", in_ready, (sz != 2));
        chk("rf_we", rf_we, exp_we);
        mfwd(rd_addr_a, h, d);
        chk("fwd_hit_a", fwd_hit_a, h);
        chk("fwd_data_a", fwd_data_a, d);
        mfwd(rd_addr_b, h, d);
        chk("fwd_hit_b", fwd_hit_b, h);
        chk("fwd_data_b", fwd_data_b, d);
        bad = 0;
        for (int r = 0; r < 16; r++) if (dut_rf[r] !== gold_rf[r]) bad++;
        chk("rf_state_bad_regs", bad, 0);
`ifndef WB_ZERO_REG_EN
        if (sz != 0) begin
            chk("rf_op2", rf_op2, mq[0].w2);
            chk("rf_addr1", rf_addr1, mq[0].a1);
            chk("rf_data1", rf_data1, mq[0].d1);
            if (mq[0].w2) begin
                chk("rf_addr2", rf_addr2, mq[0].a2);
                chk("rf_data2", rf_data2, mq[0].d2);
            end
        end
`endif
    endtask

    always @(negedge clk) begin
        #2;
        compare_all();
    end

    task automatic drive(input bit v, input bit o2, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [15:0] d1, input logic [15:0] d2, input bit h, input bit f,
                         input logic [3:0] ra, input logic [3:0] rb);
        @(negedge clk);
        in_valid = v;  in_op2 = o2;
        in_addr1 = a1; in_addr2 = a2;
        in_data1 = d1; in_data2 = d2;
        hold = h; flush = f;
        rd_addr_a = ra; rd_addr_b = rb;
        #3;
    endtask

    task automatic idle(input bit h, input logic [3:0] ra);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0, h, 1'b0, ra, 4'd0);
    endtask

    task automatic push1(input logic [3:0] a, input logic [15:0] d, input bit h, input logic [3:0] ra);
        drive(1'b1, 1'b0, a, 4'd0, d, 16'h0, h, 1'b0, ra, 4'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_op2 = 0; in_addr1 = 0; in_addr2 = 0;
        in_data1 = 0; in_data2 = 0; hold = 0; flush = 0;
        rd_addr_a = 0; rd_addr_b = 0;
        #1 rst = 1'b0;
        @(negedge clk); #3;
        chk("reset_count", count, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_fwd_hit_a", fwd_hit_a, 0);
        rst = 1'b1;

        // single write
        push1(4'd3, 16'h1234, 1'b0, 4'd3);
        chk("single_no_incoming_fwd", fwd_hit_a, 0);
        idle(1'b0, 4'd0);
        chk("single_we", rf_we, 1);
        chk("single_addr1", rf_addr1, 4'd3);
        chk("single_data1", rf_data1, 16'h1234);
        chk("single_op2", rf_op2, 0);
        idle(1'b0, 4'd0);
        chk("single_count_after", count, 0);
        chk("single_gold_r3", gold_rf[3], 16'h1234);

        // dual write, duplicate destination
        drive(1'b1, 1'b1, 4'd15, 4'd15, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 4'd15, 4'd0);
        idle(1'b1, 4'd15);
        chk("dup_fwd_hit", fwd_hit_a, 1);
        chk("dup_fwd_data", fwd_data_a, 16'h5555);
        idle(1'b0, 4'd15);
        idle(1'b0, 4'd0);
        chk("dup_rf_r15", dut_rf[15], 16'h5555);

        // full / backpressure
        push1(4'd1, 16'h0001, 1'b1, 4'd0);
        push1(4'd2, 16'h0002, 1'b1, 4'd0);
        push1(4'd3, 16'h0003, 1'b1, 4'd2);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 2);
        chk("full_fwd_r2", fwd_data_a, 16'h0002);
        push1(4'd3, 16'h0003, 1'b0, 4'd0);
        chk("full_ret1_addr", rf_addr1, 4'd1);
        chk("full_ret1_ready", in_ready, 0);
        push1(4'd3, 16'h0003, 1'b0, 4'd0);
        chk("full_ret2_addr", rf_addr1, 4'd2);
        chk("full_ret2_count", count, 1);
        idle(1'b0, 4'd0);
        chk("full_ret3_addr", rf_addr1, 4'd3);
        chk("full_ret3_data", rf_data1, 16'h0003);
        idle(1'b0, 4'd0);
        chk("full_drained", count, 0);

        // youngest wins
        push1(4'd5, 16'h0010, 1'b1, 4'd0);
        push1(4'd5, 16'h0020, 1'b1, 4'd0);
        idle(1'b1, 4'd5);
        chk("young_data", fwd_data_a, 16'h0020);
        idle(1'b0, 4'd5);
        idle(1'b1, 4'd5);
        chk("young_after_pop_count", count, 1);
        chk("young_after_pop_data", fwd_data_a, 16'h0020);
        idle(1'b0, 4'd0);
        idle(1'b0, 4'd0);

        // flush with two entries, then with one entry and a live accept
        push1(4'd6, 16'h0066, 1'b1, 4'd0);
        push1(4'd7, 16'h0077, 1'b1, 4'd0);
        drive(1'b1, 1'b0, 4'd8, 4'd0, 16'h0088, 16'h0, 1'b1, 1'b1, 4'd7, 4'd0);
        chk("flush_we", rf_we, 0);
        idle(1'b0, 4'd7);
        chk("flush_count", count, 0);
        chk("flush_fwd", fwd_hit_a, 0);
        push1(4'd9, 16'h0099, 1'b1, 4'd0);
        drive(1'b1, 1'b0, 4'd10, 4'd0, 16'h00AA, 16'h0, 1'b1, 1'b1, 4'd10, 4'd0);
        idle(1'b0, 4'd10);
        chk("flush_drop_count", count, 0);
        chk("flush_drop_we", rf_we, 0);
        idle(1'b0, 4'd0);
        chk("flush_no_write_r10", dut_rf[10], 16'h0);

        // reset mid-stream, no clock edge needed
        push1(4'd11, 16'h0B0B, 1'b1, 4'd0);
        push1(4'd12, 16'h0C0C, 1'b1, 4'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_we", rf_we, 0);
        chk("rst_mid_ready", in_ready, 1);
        in_valid = 0; hold = 0; flush = 0;
        @(negedge clk); #1 rst = 1'b1;
        idle(1'b0, 4'd0);
        idle(1'b0, 4'd0);
        chk("rst_no_stale_r11", dut_rf[11], 16'h0);
        chk("rst_no_stale_r12", dut_rf[12], 16'h0);

        // register 0
        push1(4'd0, 16'hBEEF, 1'b0, 4'd0);
        idle(1'b0, 4'd0);
`ifdef WB_ZERO_REG_EN
        chk("r0_we", rf_we, 0);
        chk("r0_count", count, 1);
        chk("r0_fwd_hit", fwd_hit_a, 0);
`else
        chk("r0_we", rf_we, 1);
        chk("r0_fwd_hit", fwd_hit_a, 1);
        chk("r0_fwd_data", fwd_data_a, 16'hBEEF);
`endif
        idle(1'b0, 4'd0);
        chk("r0_drained", count, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          v, o2, h, f;
            logic [3:0]  a1, a2, ra, rb;
            logic [15:0] d1, d2;
            v  = ($urandom_range(0, 99) < 65);
            o2 = $urandom_range(0, 1) != 0;
            h  = ($urandom_range(0, 99) < 30);
            f  = h && ($urandom_range(0, 99) < 8);
            a1 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 3));
            rb = 4'($urandom_range(0, 15));
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            drive(v, o2, a1, a2, d1, d2, h, f, ra, rb);
            if (i == 1500) begin
                rst = 1'b0;
                #1;
                chk("rand_rst_count", count, 0);
                @(negedge clk); #1 rst = 1'b1;
            end
        end
        idle(1'b0, 4'd0);
        idle(1'b0, 4'd0);
        idle(1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
